fsm_job_dispatcher: RTL

Upstream control stage for the 16-cycle go/done counter FSM. It accepts job requests, keeps a count of pending jobs, and issues a single-cycle go to the counter. It then waits for the counter's done, counts completed jobs, and flags a timeout if done never arrives. A watchdog stops a lost done from hanging the dispatcher.

---
 rtl/fsm_job_dispatcher_if.sv | 41 ++++
 rtl/fsm_job_dispatcher.sv | 111 +++++++++++
 2 files changed

// File: rtl/fsm_job_dispatcher_if.sv
// Handshake bundle between the job dispatcher, its requester and the
// 16-cycle go/done counter FSM. The master side is the environment
// (requester plus counter); the slave side is the dispatcher itself.
interface fsm_job_dispatcher_if #(
    parameter int PEND_W = 3,
    parameter int DONE_W = 8
);
    logic              req;
    logic              req_ready;
    logic              go;
    logic              done;
    logic              clr_err;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic [DONE_W-1:0] jobs_done;
    logic              timeout_err;

    modport master (
        output req,
        output done,
        output clr_err,
        input  req_ready,
        input  go,
        input  busy,
        input  pending,
        input  jobs_done,
        input  timeout_err
    );

    modport slave (
        input  req,
        input  done,
        input  clr_err,
        output req_ready,
        output go,
        output busy,
        output pending,
        output jobs_done,
        output timeout_err
    );
endinterface

// File: rtl/fsm_job_dispatcher.sv
// Job dispatcher feeding the 16-cycle go/done counter FSM.
// Accepts job requests into a saturating pending count, issues one go pulse
// per job, waits for done with a watchdog timer, counts completed jobs and
// raises a sticky timeout flag when a done is lost. All outputs are Moore:
// decoded from registered state/counters, never from req or done directly.
module fsm_job_dispatcher #(
    parameter int PEND_W  = 3,
    parameter int TIMEOUT = 20,
    parameter int DONE_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fsm_job_dispatcher_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    // Timer only needs to reach TIMEOUT-1 before the watchdog fires.
    localparam int                TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t             r_state;
    logic [PEND_W-1:0]  r_pending;
    logic [DONE_W-1:0]  r_jobs_done;
    logic [TMR_W-1:0]   r_timer;
    logic               r_timeout_err;

    logic               w_ready;
    logic               w_accept;
    logic               w_done_ret;
    logic               w_tmo_ret;
    logic               w_retire;

    // Ready comes from the registered count, so it lags the accepting edge.
    assign w_ready    = (r_pending != PEND_MAX);
    assign w_accept   = bus.req && w_ready;
    // done only matters while waiting; it beats a coincident timeout.
    assign w_done_ret = (r_state == S_WAIT) && bus.done;
    assign w_tmo_ret  = (r_state == S_WAIT) && !bus.done && (r_timer == TMR_LAST);
    // The in-flight job is part of pending, so pending is never zero here;
    // the guard just keeps the counter from ever wrapping downwards.
    assign w_retire   = (w_done_ret || w_tmo_ret) && (r_pending != '0);

    // Control FSM: state, watchdog timer, completion count and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_jobs_done   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pending != '0) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_done_ret) begin
                        r_jobs_done <= r_jobs_done + 1'b1;
                        r_state     <= S_IDLE;
                    end else if (w_tmo_ret) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_ERROR;
                    end
                end
                S_ERROR: begin
                    if (bus.clr_err) begin
                        r_timeout_err <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pending-job counter: accept and retire in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            case ({w_accept, w_retire})
                2'b10:   r_pending <= r_pending + 1'b1;
                2'b01:   r_pending <= r_pending - 1'b1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.go          = (r_state == S_ISSUE);
    assign bus.busy        = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign bus.pending     = r_pending;
    assign bus.jobs_done   = r_jobs_done;
    assign bus.timeout_err = r_timeout_err;

endmodule
